// File: rtl/clk_branch_sequencer.sv
// Clock-branch enable sequencer: round-robin staggered turn-on, settle-delayed ACK, idle-timeout turn-off.
// Optional scan test enable port TE is present when CLKSEQ_TEST_EN is defined.
module clk_branch_sequencer #(
    parameter int N_BR    = 4,
    parameter int STAGGER = 4,
    parameter int SETTLE  = 2,
    parameter int IDLE_W  = 8
) (
    input  logic              CLK,
    input  logic              RN,
`ifdef CLKSEQ_TEST_EN
    input  logic              TE,
`endif
    input  logic [N_BR-1:0]   REQ,
    input  logic [IDLE_W-1:0] IDLE_TMO,
    output logic [N_BR-1:0]   EN,
    output logic [N_BR-1:0]   ACK,
    output logic              BUSY
);

    localparam int PTR_W = (N_BR > 1) ? $clog2(N_BR) : 1;
    localparam int STG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int SET_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {S_OFF, S_WAIT, S_ON, S_HOLD} br_state_e;

    br_state_e         state_q  [N_BR];
    br_state_e         state_d  [N_BR];
    logic [IDLE_W-1:0] idle_q   [N_BR];
    logic [IDLE_W-1:0] idle_d   [N_BR];
    logic [SET_W-1:0]  settle_q [N_BR];
    logic [SET_W-1:0]  settle_d [N_BR];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [STG_W-1:0]  stag_q, stag_d;
    logic              busy_q, busy_d;

    logic              gnt_vld;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  cand;
    logic              freeze;

`ifdef CLKSEQ_TEST_EN
    assign freeze = TE;
`else
    assign freeze = 1'b0;
`endif

    // Round-robin search; scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        if (stag_q == '0) begin
            for (int k = N_BR - 1; k >= 0; k--) begin
                sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(N_BR)) begin
                    sum = sum - (PTR_W+1)'(N_BR);
                end
                cand = sum[PTR_W-1:0];
                if (state_q[cand] == S_WAIT && REQ[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            for (int i = 0; i < N_BR; i++) begin
                state_q[i]  <= S_OFF;
                idle_q[i]   <= '0;
                settle_q[i] <= '0;
            end
            ptr_q  <= '0;
            stag_q <= '0;
            busy_q <= 1'b0;
        end else if (!freeze) begin
            for (int i = 0; i < N_BR; i++) begin
                state_q[i]  <= state_d[i];
                idle_q[i]   <= idle_d[i];
                settle_q[i] <= settle_d[i];
            end
            ptr_q  <= ptr_d;
            stag_q <= stag_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < N_BR; i++) begin
            state_d[i]  = state_q[i];
            idle_d[i]   = idle_q[i];
            settle_d[i] = settle_q[i];
            if ((state_q[i] == S_ON || state_q[i] == S_HOLD) && settle_q[i] != '0) begin
                settle_d[i] = settle_q[i] - SET_W'(1);
            end
            case (state_q[i])
                S_OFF: begin
                    if (REQ[i]) state_d[i] = S_WAIT;
                end
                S_WAIT: begin
                    if (!REQ[i]) begin
                        state_d[i] = S_OFF;
                    end else if (gnt_vld && gnt_idx == PTR_W'(i)) begin
                        state_d[i]  = S_ON;
                        settle_d[i] = SET_W'(SETTLE);
                    end
                end
                S_ON: begin
                    if (!REQ[i]) begin
                        state_d[i] = S_HOLD;
                        idle_d[i]  = IDLE_TMO;
                    end
                end
                S_HOLD: begin
                    // A re-request wins over an expiring idle count.
                    if (REQ[i]) begin
                        state_d[i] = S_ON;
                    end else if (idle_q[i] == '0) begin
                        state_d[i]  = S_OFF;
                        settle_d[i] = '0;
                    end else begin
                        idle_d[i] = idle_q[i] - IDLE_W'(1);
                    end
                end
                default: state_d[i] = S_OFF;
            endcase
            busy_d = busy_d | (state_d[i] == S_WAIT);
        end

        ptr_d = ptr_q;
        if (stag_q != '0) begin
            stag_d = stag_q - STG_W'(1);
        end else begin
            stag_d = stag_q;
        end
        if (gnt_vld) begin
            ptr_d  = (gnt_idx == PTR_W'(N_BR - 1)) ? '0 : gnt_idx + PTR_W'(1);
            stag_d = STG_W'(STAGGER - 1);
        end
    end

    always_comb begin
        EN  = '0;
        ACK = '0;
        for (int i = 0; i < N_BR; i++) begin
            EN[i]  = (state_q[i] == S_ON) || (state_q[i] == S_HOLD);
            ACK[i] = ((state_q[i] == S_ON) || (state_q[i] == S_HOLD)) && (settle_q[i] == '0);
        end
`ifdef CLKSEQ_TEST_EN
        if (TE) begin
            EN  = '1;
            ACK = '1;
        end
`endif
    end

    assign BUSY = busy_q;

endmodule

// File: tb/tb_clk_branch_sequencer.sv
// Bench for clk_branch_sequencer: time-based reference model compared every cycle, plus directed literal checks.
module tb_clk_branch_sequencer;
    localparam int N   = 4;
    localparam int STG = 4;
    localparam int STL = 2;
    localparam int IW  = 8;

    logic          clk = 1'b0;
    logic          rn;
    logic [N-1:0]  req;
    logic [IW-1:0] tmo;
    logic [N-1:0]  en;
    logic [N-1:0]  ack;
    logic          busy;
`ifdef CLKSEQ_TEST_EN
    logic          te = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int edge_n = 0;

    // Reference model: branch status plus absolute edge times for ACK and turn-off.
    bit m_wait   [N];
    bit m_on     [N];
    int m_ack_at [N];
    int m_off_at [N];
    int m_ptr  = 0;
    int m_next = 0;
    logic [N-1:0] m_xe, m_xa;
    logic         m_xb;
    int ex;

    always #5 clk = ~clk;

    clk_branch_sequencer #(
        .N_BR(N), .STAGGER(STG), .SETTLE(STL), .IDLE_W(IW)
    ) dut (
        .CLK(clk),
        .RN(rn),
`ifdef CLKSEQ_TEST_EN
        .TE(te),
`endif
        .REQ(req),
        .IDLE_TMO(tmo),
        .EN(en),
        .ACK(ack),
        .BUSY(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_step(input int e);
        int g;
        g = -1;
        if (!rn) begin
            for (int i = 0; i < N; i++) begin
                m_wait[i] = 1'b0; m_on[i] = 1'b0; m_ack_at[i] = 0; m_off_at[i] = -1;
            end
            m_ptr  = 0;
            m_next = e + 1;
            return;
        end
        if (e >= m_next) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (g < 0 && m_wait[i] && req[i]) g = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_wait[i]) begin
                if (!req[i]) m_wait[i] = 1'b0;
                else if (i == g) begin
                    m_wait[i] = 1'b0; m_on[i] = 1'b1; m_ack_at[i] = e + STL; m_off_at[i] = -1;
                end
            end else if (!m_on[i]) begin
                if (req[i]) m_wait[i] = 1'b1;
            end else if (m_off_at[i] < 0) begin
                if (!req[i]) m_off_at[i] = e + int'(tmo) + 1;
            end else if (req[i]) begin
                m_off_at[i] = -1;
            end else if (e == m_off_at[i]) begin
                m_on[i] = 1'b0; m_off_at[i] = -1;
            end
        end
        if (g >= 0) begin
            m_ptr  = (g + 1) % N;
            m_next = e + STG;
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        model_step(edge_n);
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            m_xe = '0; m_xa = '0; m_xb = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_xe[i] = m_on[i];
                m_xa[i] = m_on[i] && (edge_n >= m_ack_at[i]);
                m_xb    = m_xb | m_wait[i];
            end
            check("model_en",   32'(en),   32'(m_xe));
            check("model_ack",  32'(ack),  32'(m_xa));
            check("model_busy", 32'(busy), 32'(m_xb));
        end
    end

    initial begin
        rn = 1'b0; req = '0; tmo = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_en", 32'(en), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        rn = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check("idle_en", 32'(en), 0);
            check("idle_busy", 32'(busy), 0);
        end

        // Single request: EN after t+1, ACK after t+3.
        req = 4'b0001;
        @(negedge clk); check("t0_en", 32'(en), 0); check("t0_busy", 32'(busy), 1);
        @(negedge clk); check("t1_en", 32'(en), 1); check("t1_ack", 32'(ack), 0);
        @(negedge clk); check("t2_ack", 32'(ack), 0);
        @(negedge clk); check("t3_ack", 32'(ack), 1);

        // IDLE_TMO=0: off one edge after HOLD entry.
        req = 4'b0000;
        @(negedge clk); check("h0_en", 32'(en), 1);
        @(negedge clk); check("h1_en", 32'(en), 0); check("h1_ack", 32'(ack), 0);
        repeat (4) @(negedge clk);

        // All four request together from pointer 0.
        rn = 1'b0;
        @(negedge clk);
        rn = 1'b1; req = 4'b1111;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            ex = (k >= 13) ? 15 : (k >= 9) ? 7 : (k >= 5) ? 3 : (k >= 1) ? 1 : 0;
            check("stag_en", 32'(en), 32'(ex));
            check("stag_busy", 32'(busy), 32'(k < 13));
        end
        repeat (3) @(negedge clk);
        check("all_ack", 32'(ack), 15);

        // Branch 2 idle timeout of 3; a later IDLE_TMO change must be ignored.
        tmo = 8'd3; req = 4'b1011;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) tmo = 8'd0;
            check("tmo_en2", 32'(en[2]), 32'(k < 4));
            check("tmo_ack2", 32'(ack[2]), 32'(k < 4));
        end

        // Re-request two cycles into HOLD keeps branch 2 running.
        tmo = 8'd3; req = 4'b1111;
        repeat (5) @(negedge clk);
        check("re_en", 32'(en), 15); check("re_ack", 32'(ack), 15);
        req = 4'b1011;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) req = 4'b1111;
            check("keep_en2", 32'(en[2]), 1);
            check("keep_ack2", 32'(ack[2]), 1);
        end

        // Short REQ[1] pulse while stagger counter is busy.
        req = 4'b0000; tmo = 8'd0;
        repeat (6) @(negedge clk);
        check("drain_en", 32'(en), 0);
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk); check("p_en0", 32'(en), 1); req = 4'b0011;
        @(negedge clk); check("p_busy1", 32'(busy), 1); check("p_en1", 32'(en), 1); req = 4'b0001;
        @(negedge clk); check("p_busy0", 32'(busy), 0);
        repeat (6) begin
            @(negedge clk);
            check("p_en_b1", 32'(en[1]), 0);
        end

        // Reset with three branches on.
        req = 4'b0111;
        repeat (10) @(negedge clk);
        check("three_en", 32'(en), 7); check("three_ack", 32'(ack), 7);
        rn = 1'b0;
        @(negedge clk);
        check("mrst_en", 32'(en), 0); check("mrst_ack", 32'(ack), 0); check("mrst_busy", 32'(busy), 0);
        rn = 1'b1; req = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
